// File: rtl/router_pkg.sv
// Shared flit format and link handshake definitions for the mesh router
// and its local-port endpoints (traffic generator / traffic sink).
package router_pkg;

  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    HEAD      = 2'd0,
    BODY      = 2'd1,
    TAIL      = 2'd2,
    HEAD_TAIL = 2'd3
  } flit_type_t;

  typedef struct packed {
    flit_type_t           flit_type;
    logic [COORD_W-1:0]   dst_x;
    logic [COORD_W-1:0]   dst_y;
    logic [PAYLOAD_W-1:0] payload;
  } FLIT_t;

  // Link handshake: the sender may assert req only while the receiver's
  // on_off is LINK_ON; the receiver drops it early enough to absorb the
  // flits still in flight over the link round-trip.
  localparam logic LINK_ON  = 1'b1;
  localparam logic LINK_OFF = 1'b0;

  typedef enum logic {
    CHK_IDLE   = 1'b0,
    CHK_IN_PKT = 1'b1
  } chk_state_t;

  function automatic logic is_head(input flit_type_t t);
    return (t == HEAD) || (t == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/sink_fifo.sv
// Synchronous FIFO for the traffic sink; pops are suppressed when empty and
// pushes are refused when full unless a pop frees the slot in the same cycle.
module sink_fifo
  import router_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = FLIT_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  T                           data_i,
  output T                           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [$clog2(DEPTH+1)-1:0] count_next_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  T               mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/traffic_sink.sv
// Local-port consumer: buffers router flits, drains them at a programmable
// rate and checks packet ordering and head-flit destination.
module traffic_sink
  import router_pkg::*;
#(
  parameter int XADDR         = 0,
  parameter int YADDR         = 0,
  parameter int FIFO_DEPTH    = 4,
  parameter int OFF_THRESHOLD = 2,
  parameter int DRAIN_PERIOD  = 1,
  parameter int CNT_W         = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  FLIT_t                           i_flit,
  input  logic                            i_req,
  input  logic                            i_drain_en,
  output logic                            o_on_off,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_occupancy,
  output logic [CNT_W-1:0]                o_flit_count,
  output logic [CNT_W-1:0]                o_pkt_count,
  output logic [CNT_W-1:0]                o_dest_err_count,
  output logic [CNT_W-1:0]                o_proto_err_count,
  output logic                            o_overflow
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int DRN_W = $clog2(DRAIN_PERIOD + 1);
  localparam logic [OCC_W-1:0]   ON_LIMIT = OCC_W'(FIFO_DEPTH - OFF_THRESHOLD);
  localparam logic [DRN_W-1:0]   DRN_LAST = DRN_W'(DRAIN_PERIOD - 1);
  localparam logic [DRN_W-1:0]   DRN_ONE  = DRN_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [COORD_W-1:0] MY_X     = COORD_W'(XADDR);
  localparam logic [COORD_W-1:0] MY_Y     = COORD_W'(YADDR);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             en);
    return (en && (c != '1)) ? c + CNT_ONE : c;
  endfunction

  FLIT_t             pop_flit;
  logic              fifo_full, fifo_empty;
  logic [OCC_W-1:0]  occ, occ_next;
  logic              push, pop, tick;
  logic [DRN_W-1:0]  drn_cnt_q, drn_cnt_d;
  logic              on_off_q, on_off_d;
  logic              ovf_q, ovf_d;
  chk_state_t        state_q, state_d;
  logic              pkt_inc, dest_inc, proto_inc, dest_bad;
  logic [CNT_W-1:0]  flit_cnt_q, flit_cnt_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]  dest_cnt_q, dest_cnt_d;
  logic [CNT_W-1:0]  proto_cnt_q, proto_cnt_d;
  logic              unused_payload;

  // The checker never looks at payload contents.
  assign unused_payload = ^pop_flit.payload;

  assign pop  = tick && !fifo_empty;
  assign push = i_req && (!fifo_full || pop);

  sink_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (FLIT_t)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (pop),
    .data_i       (i_flit),
    .data_o       (pop_flit),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (occ),
    .count_next_o (occ_next)
  );

  always_comb begin
    tick      = i_drain_en && (drn_cnt_q == DRN_LAST);
    drn_cnt_d = drn_cnt_q + DRN_ONE;
    if (!i_drain_en || tick) drn_cnt_d = '0;
  end

  assign on_off_d = (occ_next <= ON_LIMIT) ? LINK_ON : LINK_OFF;
  assign ovf_d    = ovf_q || (i_req && fifo_full && !pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      drn_cnt_q <= '0;
      on_off_q  <= LINK_OFF;
      ovf_q     <= 1'b0;
    end else begin
      drn_cnt_q <= drn_cnt_d;
      on_off_q  <= on_off_d;
      ovf_q     <= ovf_d;
    end
  end

  // Checker FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= CHK_IDLE;
    else       state_q <= state_d;
  end

  // Checker FSM: next state. A head always (re)starts a packet, even one
  // that arrives mid-packet, so the outcome depends only on the flit type.
  always_comb begin
    state_d = state_q;
    if (pop) begin
      unique case (pop_flit.flit_type)
        HEAD:      state_d = CHK_IN_PKT;
        HEAD_TAIL: state_d = CHK_IDLE;
        TAIL:      state_d = CHK_IDLE;
        default:   state_d = state_q;
      endcase
    end
  end

  // Checker FSM: per-flit event outputs
  always_comb begin
    dest_bad  = (pop_flit.dst_x != MY_X) || (pop_flit.dst_y != MY_Y);
    pkt_inc   = 1'b0;
    dest_inc  = 1'b0;
    proto_inc = 1'b0;
    if (pop) begin
      dest_inc = is_head(pop_flit.flit_type) && dest_bad;
      if (state_q == CHK_IDLE) begin
        proto_inc = !is_head(pop_flit.flit_type);
        pkt_inc   = (pop_flit.flit_type == HEAD_TAIL);
      end else begin
        proto_inc = is_head(pop_flit.flit_type);
        pkt_inc   = (pop_flit.flit_type == TAIL) ||
                    (pop_flit.flit_type == HEAD_TAIL);
      end
    end
  end

  always_comb begin
    flit_cnt_d  = sat_inc(flit_cnt_q,  pop);
    pkt_cnt_d   = sat_inc(pkt_cnt_q,   pkt_inc);
    dest_cnt_d  = sat_inc(dest_cnt_q,  dest_inc);
    proto_cnt_d = sat_inc(proto_cnt_q, proto_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      dest_cnt_q  <= '0;
      proto_cnt_q <= '0;
    end else begin
      flit_cnt_q  <= flit_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      dest_cnt_q  <= dest_cnt_d;
      proto_cnt_q <= proto_cnt_d;
    end
  end

  assign o_on_off          = on_off_q;
  assign o_occupancy       = occ;
  assign o_flit_count      = flit_cnt_q;
  assign o_pkt_count       = pkt_cnt_q;
  assign o_dest_err_count  = dest_cnt_q;
  assign o_proto_err_count = proto_cnt_q;
  assign o_overflow        = ovf_q;

endmodule
